// File: rtl/mnist_nn_pkg.sv
// Shared types, default widths and saturation helpers for the MNIST layer engines.
package mnist_nn_pkg;

  localparam int DEF_N_INPUTS = 784;
  localparam int DEF_N_NEUR   = 10;
  localparam int DEF_IN_W     = 16;
  localparam int DEF_W_W      = 16;
  localparam int DEF_ACC_W    = 40;
  localparam int DEF_FRAC     = 8;
  localparam int DEF_OUT_W    = 16;
  // Working width for saturating arithmetic; must exceed ACC_W by at least one bit.
  localparam int CALC_W       = 64;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, BIAS, OUT} state_t;

  function automatic logic signed [CALC_W-1:0] sat_w(input logic signed [CALC_W-1:0] x,
                                                     input int unsigned w);
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (CALC_W'(1) <<< (w - 1)) - CALC_W'(1);
    lo = ~hi;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic signed [CALC_W-1:0] relu(input logic signed [CALC_W-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

endpackage

// File: rtl/mnist_mac_lane.sv
// One neuron lane: saturating multiply-accumulate, bias add, shift, activation, output register.
module mnist_mac_lane
  import mnist_nn_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int W_W      = DEF_W_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int FRAC     = DEF_FRAC,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int ACT_RELU = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clr,
  input  logic                    i_mac_en,
  input  logic                    i_bias_en,
  input  logic                    i_out_en,
  input  logic signed [IN_W-1:0]  i_data,
  input  logic signed [W_W-1:0]   i_weight,
  input  logic signed [W_W-1:0]   i_bias,
  output logic signed [OUT_W-1:0] o_result
);

  logic signed [IN_W+W_W-1:0] w_prod;
  logic signed [CALC_W-1:0]   w_addend;
  logic signed [CALC_W-1:0]   w_sum_sat;
  logic signed [CALC_W-1:0]   w_act;
  logic signed [CALC_W-1:0]   w_out;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod = i_data * i_weight;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_addend  = CALC_W'(w_prod);
    if (i_bias_en) w_addend = CALC_W'(i_bias) <<< FRAC;
    // Sum is formed wider than ACC_W, so clamping replaces wrap-around.
    w_sum_sat = sat_w(CALC_W'(r_acc) + w_addend, ACC_W);
    w_act     = CALC_W'(r_acc) >>> FRAC;
    if (ACT_RELU != 0) w_act = relu(w_act);
    w_out     = sat_w(w_act, OUT_W);
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      o_result <= '0;
    end else begin
      if (i_clr)                      r_acc <= '0;
      else if (i_mac_en || i_bias_en) r_acc <= w_sum_sat[ACC_W-1:0];
      if (i_out_en)                   o_result <= w_out[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mnist_layer_engine.sv
// Fully-connected layer engine: address sequencing FSM driving N_NEUR parallel MAC lanes.
module mnist_layer_engine
  import mnist_nn_pkg::*;
#(
  parameter int N_INPUTS = DEF_N_INPUTS,
  parameter int N_NEUR   = DEF_N_NEUR,
  parameter int IN_W     = DEF_IN_W,
  parameter int W_W      = DEF_W_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int FRAC     = DEF_FRAC,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int ACT_RELU = 1,
  parameter int ADDR_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      clear,
  output logic                      busy,
  output logic [ADDR_W-1:0]         inp_count,
  output logic [ADDR_W-1:0]         inp_count_d,
  input  logic signed [IN_W-1:0]    inp_data,
  input  logic [N_NEUR*W_W-1:0]     weight_value,
  input  logic [N_NEUR*W_W-1:0]     bias_value,
  output logic [N_NEUR*OUT_W-1:0]   result,
  output logic                      done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

  state_t r_state;
  state_t w_next;
  logic   r_valid_d;
  logic   r_drain_2nd;
  logic   r_done;
  logic   w_start_ok;
  logic   w_last;

  assign w_start_ok = (r_state == IDLE) && start && !clear;
  assign w_last     = (inp_count == LAST_ADDR);
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_next = FETCH;
        FETCH:   if (w_last) w_next = DRAIN;
        DRAIN:   if (r_drain_2nd) w_next = BIAS;
        BIAS:    w_next = OUT;
        OUT:     w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_valid_d   <= 1'b0;
      r_drain_2nd <= 1'b0;
      r_done      <= 1'b0;
      inp_count   <= '0;
      inp_count_d <= '0;
    end else begin
      r_state     <= w_next;
      r_valid_d   <= (r_state == FETCH) && !clear;
      r_drain_2nd <= (r_state == DRAIN) && !r_drain_2nd && !clear;
      r_done      <= (r_state == OUT) && !clear;
      inp_count_d <= inp_count;
      // Address holds through DRAIN/BIAS and returns to 0 once the run completes.
      if (clear || w_start_ok || r_state == OUT) inp_count <= '0;
      else if (r_state == FETCH && !w_last)      inp_count <= inp_count + 1'b1;
    end
  end

  for (genvar g = 0; g < N_NEUR; g++) begin : g_lane
    mnist_mac_lane #(
      .IN_W    (IN_W),
      .W_W     (W_W),
      .ACC_W   (ACC_W),
      .FRAC    (FRAC),
      .OUT_W   (OUT_W),
      .ACT_RELU(ACT_RELU)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_clr    (w_start_ok),
      .i_mac_en (r_valid_d && !clear),
      .i_bias_en((r_state == BIAS) && !clear),
      .i_out_en ((r_state == OUT) && !clear),
      .i_data   (inp_data),
      .i_weight (weight_value[g*W_W +: W_W]),
      .i_bias   (bias_value[g*W_W +: W_W]),
      .o_result (result[g*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_mnist_layer_engine.sv
// Self-checking bench: a ReLU and a linear engine share one small input/weight memory model.
module tb_mnist_layer_engine;

  localparam int N   = 4;
  localparam int NN  = 2;
  localparam int IW  = 16;
  localparam int WW  = 16;
  localparam int AW  = 40;
  localparam int FR  = 0;
  localparam int OW  = 16;
  localparam int ADW = 2;

  typedef struct {
    int in_v[N];
    int w0[N];
    int w1[N];
    int b0, b1;
    int er0, er1;   // expected ReLU outputs
    int el0, el1;   // expected linear outputs
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic clear = 1'b0;
  logic busy_r, busy_l, done_r, done_l;
  logic [ADW-1:0] cnt_r, cnt_d_r, cnt_l, cnt_d_l;
  logic signed [IW-1:0] inp_data;
  logic [NN*WW-1:0] weight_value;
  logic [NN*WW-1:0] bias_value = '0;
  logic [NN*OW-1:0] res_r, res_l;

  logic signed [15:0] in_mem [N];
  logic signed [15:0] w_mem  [N][NN];
  logic signed [15:0] b_mem  [NN];

  int n_checks = 0;
  int n_err = 0;
  vec_t vecs[4];

  always #5 clk = ~clk;

  // Sync-read memories: data for the address presented at an edge appears after that edge.
  always @(posedge clk) begin
    inp_data <= in_mem[cnt_r];
    for (int l = 0; l < NN; l++) weight_value[l*WW +: WW] <= w_mem[cnt_r][l];
  end

  mnist_layer_engine #(.N_INPUTS(N), .N_NEUR(NN), .IN_W(IW), .W_W(WW), .ACC_W(AW),
                       .FRAC(FR), .OUT_W(OW), .ACT_RELU(1)) u_relu (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .busy(busy_r),
    .inp_count(cnt_r), .inp_count_d(cnt_d_r), .inp_data(inp_data),
    .weight_value(weight_value), .bias_value(bias_value), .result(res_r), .done(done_r));

  mnist_layer_engine #(.N_INPUTS(N), .N_NEUR(NN), .IN_W(IW), .W_W(WW), .ACC_W(AW),
                       .FRAC(FR), .OUT_W(OW), .ACT_RELU(0)) u_lin (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .busy(busy_l),
    .inp_count(cnt_l), .inp_count_d(cnt_d_l), .inp_data(inp_data),
    .weight_value(weight_value), .bias_value(bias_value), .result(res_l), .done(done_l));

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [63:0] lane_of(input logic [NN*OW-1:0] r, input int l);
    logic signed [OW-1:0] t;
    t = r[l*OW +: OW];
    return 64'(t);
  endfunction

  function automatic longint clamp(input longint x, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  // Reference neuron: dot product with clamped running sum, bias, shift, activation, clamp.
  function automatic longint ref_lane(input int l, input bit use_relu);
    longint acc, v;
    acc = 0;
    for (int k = 0; k < N; k++) acc = clamp(acc + longint'(in_mem[k]) * longint'(w_mem[k][l]), AW);
    acc = clamp(acc + (longint'(b_mem[l]) <<< FR), AW);
    v = acc >>> FR;
    if (use_relu && v < 0) v = 0;
    return clamp(v, OW);
  endfunction

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < N; k++) begin
      in_mem[k]   = 16'(v.in_v[k]);
      w_mem[k][0] = 16'(v.w0[k]);
      w_mem[k][1] = 16'(v.w1[k]);
    end
    b_mem[0] = 16'(v.b0);
    b_mem[1] = 16'(v.b1);
    for (int l = 0; l < NN; l++) bias_value[l*WW +: WW] = b_mem[l];
  endtask

  task automatic check_results(input string tag, input longint er0, input longint er1,
                               input longint el0, input longint el1);
    check({tag, "_relu_lane0"}, lane_of(res_r, 0), er0);
    check({tag, "_relu_lane1"}, lane_of(res_r, 1), er1);
    check({tag, "_lin_lane0"},  lane_of(res_l, 0), el0);
    check({tag, "_lin_lane1"},  lane_of(res_l, 1), el1);
  endtask

  // Pulse start, wait (bounded) for done, then verify latency and the one-cycle pulse.
  task automatic run_layer(input string tag);
    int n;
    n = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy"}, busy_r, 1);
    while (!done_r && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, N + 4);
    check({tag, "_done_lin"}, done_l, 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, done_r, 0);
    check({tag, "_idle_cnt"}, cnt_r, 0);
  endtask

  initial begin
    int seen;
    vec_t rv;

    vecs[0] = '{'{1, 2, 3, 4}, '{1, 1, 1, 1}, '{1, -1, 1, -1}, 0, 10, 10, 8, 10, 8};
    vecs[1] = '{'{1, 2, 3, 4}, '{1, 1, 1, 1}, '{-1, -1, -1, -1}, 0, 0, 10, 0, 10, -10};
    vecs[2] = '{'{32767, 32767, 32767, 32767}, '{32767, 32767, 32767, 32767},
                '{32767, 32767, 32767, 32767}, 0, 0, 32767, 32767, 32767, 32767};
    vecs[3] = '{'{32767, 32767, 32767, 32767}, '{32767, 32767, 32767, 32767},
                '{-32767, -32767, -32767, -32767}, 0, 0, 32767, 0, 32767, -32768};
    load_vec(vecs[0]);

    #12;
    check("rst_busy", busy_r, 0);
    check("rst_done", done_r, 0);
    check("rst_cnt", cnt_r, 0);
    check("rst_cnt_d", cnt_d_r, 0);
    check("rst_result", {32'd0, res_r}, 0);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      load_vec(vecs[i]);
      run_layer($sformatf("vec%0d", i));
      check_results($sformatf("vec%0d", i), vecs[i].er0, vecs[i].er1, vecs[i].el0, vecs[i].el1);
    end

    // Address stream, hold in DRAIN, and a start pulse during the run that must be ignored.
    load_vec(vecs[0]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("addr_0", cnt_r, 0);
    for (int k = 1; k < N; k++) begin
      @(negedge clk);
      check($sformatf("addr_%0d", k), cnt_r, k);
      check($sformatf("addr_d_%0d", k), cnt_d_r, k - 1);
      check($sformatf("busy_%0d", k), busy_r, 1);
      start = (k == 2);
    end
    @(negedge clk);
    check("addr_hold_drain", cnt_r, N - 1);
    check("addr_d_last", cnt_d_r, N - 1);
    seen = N;
    while (!done_r && seen < 60) begin
      @(negedge clk);
      seen++;
    end
    check("stream_latency", seen, N + 4);
    check_results("stream", 10, 8, 10, 8);
    repeat (3) @(negedge clk);
    check("no_queued_start", busy_r, 0);

    // clear mid-FETCH: abort, no done, previous result kept; then clear beats start in IDLE.
    load_vec(vecs[1]);
    run_layer("pre_clear");
    load_vec(vecs[0]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    check("clear_at_k2", cnt_r, 2);
    clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    check("clear_busy", busy_r, 0);
    check("clear_cnt", cnt_r, 0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_r || done_l) seen++;
      @(negedge clk);
    end
    check("clear_no_done", seen, 0);
    check_results("clear_hold", 10, 0, 10, -10);
    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    check("start_clear_idle", busy_r, 0);
    run_layer("after_clear");
    check_results("after_clear", 10, 8, 10, 8);

    // Asynchronous reset while draining.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (N) @(negedge clk);
    check("in_drain_busy", busy_r, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy_r, 0);
    check("arst_cnt", cnt_r, 0);
    check("arst_result_r", {32'd0, res_r}, 0);
    check("arst_result_l", {32'd0, res_l}, 0);
    @(negedge clk) reset = 1'b1;
    run_layer("after_rst");
    check_results("after_rst", 10, 8, 10, 8);

    // Random vectors against the reference model.
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < N; k++) begin
        rv.in_v[k] = int'($signed(16'($urandom)));
        rv.w0[k]   = int'($signed(16'($urandom)));
        rv.w1[k]   = (r < 5) ? int'($signed(16'($urandom_range(0, 15)))) - 8
                             : int'($signed(16'($urandom)));
      end
      rv.b0 = int'($signed(16'($urandom)));
      rv.b1 = int'($signed(16'($urandom)));
      load_vec(rv);
      run_layer($sformatf("rnd%0d", r));
      check_results($sformatf("rnd%0d", r), ref_lane(0, 1'b1), ref_lane(1, 1'b1),
                    ref_lane(0, 1'b0), ref_lane(1, 1'b0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
